// File: rtl/led_gpio_periph_if.sv
// Native CPU memory bus between the core (master) and a memory-mapped peripheral (slave).
interface led_gpio_periph_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/led_gpio_periph.sv
// LED peripheral: LED output register with set/clear/toggle aliases and a blink engine.
// state     | meaning
// ST_IDLE   | waiting for a selected request; accepts and performs it on the edge
// ST_RESP   | mem_ready high for this single cycle; requests are not re-accepted
module led_gpio_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          CNT_W     = 24
) (
    input  logic                     clk,
    input  logic                     resetn,
    led_gpio_periph_if.slave         bus,
    output logic [3:0]               led
);
    typedef enum logic {ST_IDLE, ST_RESP} state_t;

    localparam logic [7:0] OFF_OUT    = 8'h00;
    localparam logic [7:0] OFF_SET    = 8'h04;
    localparam logic [7:0] OFF_CLR    = 8'h08;
    localparam logic [7:0] OFF_TGL    = 8'h0C;
    localparam logic [7:0] OFF_PERIOD = 8'h10;
    localparam logic [7:0] OFF_MASK   = 8'h14;
    localparam logic [7:0] OFF_CNT    = 8'h18;

    state_t             state_q, state_d;
    logic [3:0]         led_q, led_d;
    logic [3:0]         mask_q, mask_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               sel;
    logic               accept;
    logic               wr;
    logic               wr_lo;
    logic               tick;
    logic [7:0]         offset;
    logic [3:0]         base;
    logic [31:0]        rd_val;
    logic [31:0]        period_wide;
    logic               unused_bits;

    always_comb begin
        sel    = bus.mem_valid && (bus.mem_addr[31:8] == BASE_ADDR[31:8]);
        offset = bus.mem_addr[7:0];
        accept = (state_q == ST_IDLE) && sel;
        wr     = accept && (bus.mem_wstrb != 4'b0000);
        wr_lo  = wr && bus.mem_wstrb[0];
        tick   = (period_q != '0) && (cnt_q == period_q - CNT_W'(1));
        base   = tick ? (led_q ^ mask_q) : led_q;
    end

    // Read value reflects register contents before any tick on the accepting edge.
    always_comb begin
        rd_val = '0;
        case (offset)
            OFF_OUT:    rd_val[3:0]       = led_q;
            OFF_PERIOD: rd_val[CNT_W-1:0] = period_q;
            OFF_MASK:   rd_val[3:0]       = mask_q;
            OFF_CNT:    rd_val[CNT_W-1:0] = cnt_q;
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        period_wide = '0;
        period_wide[CNT_W-1:0] = period_q;
        for (int b = 0; b < 3; b++) begin
            if (bus.mem_wstrb[b]) begin
                period_wide[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            end
        end
    end

    assign unused_bits = ^{period_wide[31:CNT_W], bus.mem_wdata[31:24]};

    always_comb begin
        state_d  = state_q;
        led_d    = base;
        mask_d   = mask_q;
        period_d = period_q;
        rdata_d  = '0;
        if (period_q == '0 || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RESP;
                    rdata_d = rd_val;
                    if (wr && offset == OFF_PERIOD) begin
                        period_d = period_wide[CNT_W-1:0];
                        cnt_d    = '0;
                    end
                    if (wr_lo) begin
                        case (offset)
                            OFF_OUT:  led_d  = bus.mem_wdata[3:0];
                            OFF_SET:  led_d  = base | bus.mem_wdata[3:0];
                            OFF_CLR:  led_d  = base & ~bus.mem_wdata[3:0];
                            OFF_TGL:  led_d  = base ^ bus.mem_wdata[3:0];
                            OFF_MASK: mask_d = bus.mem_wdata[3:0];
                            default:  led_d  = base;
                        endcase
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            led_q    <= '0;
            mask_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            led_q    <= led_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.mem_ready = (state_q == ST_RESP);
    assign bus.mem_rdata = rdata_q;
    assign led           = led_q;
endmodule

// File: tb/tb_led_gpio_periph.sv
// Directed and random bus traffic against a cycle-level reference model of the LED peripheral.
module tb_led_gpio_periph;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] led;
    int         errors = 0;
    int         checks = 0;

    led_gpio_periph_if bus ();

    led_gpio_periph #(.BASE_ADDR(BASE), .CNT_W(24)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .led    (led)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [3:0]  m_led;
    logic [3:0]  m_mask;
    int unsigned m_period;
    int unsigned m_cnt;
    logic        m_resp;
    logic [31:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_led = 4'h0; m_mask = 4'h0; m_period = 0; m_cnt = 0;
        m_resp = 1'b0; m_rdata = 32'h0;
    endtask

    function automatic logic tick_next();
        return (m_period != 0) && (((m_cnt + 1) % m_period) == 0);
    endfunction

    task automatic model_edge(input logic v, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s);
        logic        acc;
        logic [7:0]  off;
        logic [31:0] rv;
        logic [31:0] newp;
        logic [3:0]  nled;
        int unsigned ncnt;
        acc  = !m_resp && v && (a[31:8] == BASE[31:8]);
        off  = a[7:0];
        rv   = 32'h0;
        newp = m_period;
        ncnt = (m_period == 0) ? 0 : (m_cnt + 1) % m_period;
        nled = tick_next() ? (m_led ^ m_mask) : m_led;
        if (acc) begin
            case (off)
                8'h00: rv = {28'h0, m_led};
                8'h10: rv = m_period;
                8'h14: rv = {28'h0, m_mask};
                8'h18: rv = m_cnt;
                default: rv = 32'h0;
            endcase
            if (s != 4'h0 && off == 8'h10) begin
                for (int b = 0; b < 3; b++) if (s[b]) newp[8*b +: 8] = d[8*b +: 8];
                ncnt = 0;
            end
            if (s[0]) begin
                case (off)
                    8'h00: nled = d[3:0];
                    8'h04: nled = nled | d[3:0];
                    8'h08: nled = nled & ~d[3:0];
                    8'h0C: nled = nled ^ d[3:0];
                    8'h14: m_mask = d[3:0];
                    default: ;
                endcase
            end
        end
        m_period = newp;
        m_cnt    = ncnt;
        m_led    = nled;
        m_resp   = acc;
        m_rdata  = acc ? rv : 32'h0;
    endtask

    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        bus.mem_valid = v; bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wstrb = s;
        @(posedge clk);
        model_edge(v, a, d, s);
        #1;
        chk("ready", {31'h0, bus.mem_ready}, {31'h0, m_resp});
        chk("rdata", bus.mem_rdata, m_rdata);
        chk("led", {28'h0, led}, {28'h0, m_led});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        step(1'b1, BASE + {24'h0, off}, d, 4'hF);
        idle(1);
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] val);
        step(1'b1, BASE + {24'h0, off}, 32'h0, 4'h0);
        val = bus.mem_rdata;
        idle(1);
    endtask

    task automatic align_tick(input logic need_led_zero);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (tick_next() && (!need_led_zero || m_led == 4'h0)) found = 1'b1;
            else idle(1);
        end
        chk("tick_align", {31'h0, found}, 32'h1);
    endtask

    initial begin
        logic [31:0] val;
        logic [3:0]  frozen;
        logic [7:0]  offs [9];
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h40, 8'h1C};

        bus.mem_valid = 1'b0; bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0; bus.mem_wstrb = 4'h0;
        resetn = 1'b0;
        model_reset();
        #12;
        chk("rst_led", {28'h0, led}, 32'h0);
        chk("rst_ready", {31'h0, bus.mem_ready}, 32'h0);
        chk("rst_rdata", bus.mem_rdata, 32'h0);
        resetn = 1'b1;
        @(posedge clk); #1;

        rd(8'h00, val); chk("rst_out", val, 32'h0);
        rd(8'h10, val); chk("rst_period", val, 32'h0);
        rd(8'h14, val); chk("rst_mask", val, 32'h0);
        rd(8'h18, val); chk("rst_cnt", val, 32'h0);

        step(1'b1, BASE + 32'h00, 32'h5, 4'hF); chk("w_out", {28'h0, led}, 32'h5); idle(1);
        step(1'b1, BASE + 32'h04, 32'h2, 4'hF); chk("w_set", {28'h0, led}, 32'h7); idle(1);
        step(1'b1, BASE + 32'h08, 32'h4, 4'hF); chk("w_clr", {28'h0, led}, 32'h3); idle(1);
        step(1'b1, BASE + 32'h0C, 32'h9, 4'hF); chk("w_tgl", {28'h0, led}, 32'hA); idle(1);
        rd(8'h00, val); chk("rd_out", val, 32'hA);
        rd(8'h04, val); chk("rd_set_zero", val, 32'h0);

        wr(8'h14, 32'h1);
        wr(8'h00, 32'h0);
        wr(8'h10, 32'h3);
        idle(7);
        for (int i = 0; i < 6; i++) rd(8'h18, val);
        wr(8'h10, 32'h0);
        frozen = m_led;
        idle(6);
        chk("frozen_led", {28'h0, led}, {28'h0, frozen});
        rd(8'h18, val); chk("frozen_cnt", val, 32'h0);

        wr(8'h14, 32'hF);
        wr(8'h10, 32'h4);
        align_tick(1'b0);
        step(1'b1, BASE + 32'h00, 32'h6, 4'hF); chk("tick_vs_out", {28'h0, led}, 32'h6); idle(1);
        wr(8'h10, 32'h0);
        wr(8'h00, 32'h0);
        wr(8'h10, 32'h4);
        align_tick(1'b1);
        step(1'b1, BASE + 32'h04, 32'h1, 4'hF); chk("tick_vs_set", {28'h0, led}, 32'hF); idle(1);
        wr(8'h10, 32'h0);

        frozen = m_led;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, BASE + 32'h100, 32'h3, 4'hF);
            chk("outside_noready", {31'h0, bus.mem_ready}, 32'h0);
        end
        idle(1);
        step(1'b1, BASE + 32'h40, 32'hF, 4'hF);
        chk("off40_ready", {31'h0, bus.mem_ready}, 32'h1);
        chk("off40_led", {28'h0, led}, {28'h0, frozen});
        idle(1);

        step(1'b1, BASE + 32'h00, 32'h3, 4'hF);
        #2 resetn = 1'b0;
        #1;
        chk("async_ready", {31'h0, bus.mem_ready}, 32'h0);
        chk("async_led", {28'h0, led}, 32'h0);
        model_reset();
        bus.mem_valid = 1'b0;
        @(posedge clk);
        #2 resetn = 1'b1;
        step(1'b1, BASE + 32'h00, 32'h9, 4'hF); chk("post_rst_w", {28'h0, led}, 32'h9); idle(1);

        for (int i = 0; i < 300; i++) begin
            logic [7:0]  off;
            logic [31:0] a, d;
            logic [3:0]  s;
            off = offs[$urandom_range(0, 8)];
            a   = ($urandom_range(0, 7) == 0) ? (BASE + 32'h200 + {24'h0, off}) : (BASE + {24'h0, off});
            d   = (off == 8'h10) ? $urandom_range(0, 6) : $urandom;
            s   = 4'($urandom_range(0, 15));
            step(1'b1, a, d, s);
            if ($urandom_range(0, 3) == 0) step(1'b1, a, d, s);
            idle($urandom_range(0, 2) + 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
